// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback front end.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WB_XLEN    = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    data;
    } wb_entry_t;

    // Which producer drives the write port in the current cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with separate occupancy count so full/empty never alias.
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt_q == DEPTH_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem[rd_ptr_q];

    // Pointer and occupancy update; contents are not reset (discarded on flush)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered load results onto the single register-file write
// port and tracks per-register outstanding writes for RAW stall detection.
// Optional build macro WB_FWD_EN exposes the current-cycle selection
// (fwdValid/fwdRd/fwdData) for the operand-bypass mux.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 4,
    parameter int unsigned XLEN     = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issueValid,
    input  logic [4:0]                  issueRd,
    input  logic                        aluValid,
    input  logic [4:0]                  aluRd,
    input  logic [XLEN-1:0]             aluData,
    input  logic                        ldValid,
    output logic                        ldReady,
    input  logic [4:0]                  ldRd,
    input  logic [XLEN-1:0]             ldData,
    output logic                        regWrite,
    output logic [4:0]                  writeRegister,
    output logic [XLEN-1:0]             writeData,
    output logic [31:0]                 busyMask,
    output logic [$clog2(LD_DEPTH):0]   ldCount
`ifdef WB_FWD_EN
    ,
    output logic                        fwdValid,
    output logic [4:0]                  fwdRd,
    output logic [XLEN-1:0]             fwdData
`endif
);

    localparam int unsigned ENTRY_W = REG_ADDR_W + XLEN;

    wb_src_e                sel;
    logic [REG_ADDR_W-1:0]  sel_rd;
    logic [XLEN-1:0]        sel_data;
    logic                   wr_en_d;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [ENTRY_W-1:0]     fifo_head;

    logic                   reg_write_q;
    logic [REG_ADDR_W-1:0]  write_reg_q;
    logic [XLEN-1:0]        write_data_q;
    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;

    assign ldReady  = !fifo_full;
    assign fifo_pop = (sel == SRC_LD);

    wb_fifo #(
        .DEPTH (LD_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ld_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ldValid && ldReady),
        .pop   (fifo_pop),
        .wdata ({ldRd, ldData}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (ldCount)
    );

    // Source selection: ALU has no backpressure so it always wins
    always_comb begin
        sel      = SRC_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (aluValid) begin
            sel      = SRC_ALU;
            sel_rd   = aluRd;
            sel_data = aluData;
        end else if (!fifo_empty) begin
            sel      = SRC_LD;
            sel_rd   = fifo_head[ENTRY_W-1:XLEN];
            sel_data = fifo_head[XLEN-1:0];
        end
    end

    // x0 entries still consume their slot but never raise the write enable
    assign wr_en_d = (sel != SRC_NONE) && (sel_rd != '0);

    // Scoreboard next state: a new issue outranks a completing write to the same rd
    always_comb begin
        busy_d = busy_q;
        if (wr_en_d) busy_d[sel_rd] = 1'b0;
        if (issueValid && (issueRd != '0)) busy_d[issueRd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Registered write port and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            reg_write_q <= wr_en_d;
            if (sel != SRC_NONE) begin
                write_reg_q  <= sel_rd;
                write_data_q <= sel_data;
            end
            busy_q <= busy_d;
        end
    end

    assign regWrite      = reg_write_q;
    assign writeRegister = write_reg_q;
    assign writeData     = write_data_q;
    assign busyMask      = busy_q;

`ifdef WB_FWD_EN
    assign fwdValid = wr_en_d;
    assign fwdRd    = sel_rd;
    assign fwdData  = sel_data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; expected values are hand-computed.
module tb_writeback_arbiter;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            issueValid;
    logic [4:0]      issueRd;
    logic            aluValid;
    logic [4:0]      aluRd;
    logic [XLEN-1:0] aluData;
    logic            ldValid;
    logic            ldReady;
    logic [4:0]      ldRd;
    logic [XLEN-1:0] ldData;
    logic            regWrite;
    logic [4:0]      writeRegister;
    logic [XLEN-1:0] writeData;
    logic [31:0]     busyMask;
    logic [2:0]      ldCount;
`ifdef WB_FWD_EN
    logic            fwdValid;
    logic [4:0]      fwdRd;
    logic [XLEN-1:0] fwdData;
`endif

    int checks;
    int failures;

    writeback_arbiter #(
        .LD_DEPTH (4),
        .XLEN     (XLEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issueValid    (issueValid),
        .issueRd       (issueRd),
        .aluValid      (aluValid),
        .aluRd         (aluRd),
        .aluData       (aluData),
        .ldValid       (ldValid),
        .ldReady       (ldReady),
        .ldRd          (ldRd),
        .ldData        (ldData),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .busyMask      (busyMask),
        .ldCount       (ldCount)
`ifdef WB_FWD_EN
        ,
        .fwdValid      (fwdValid),
        .fwdRd         (fwdRd),
        .fwdData       (fwdData)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then stable and inputs may change
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        issueValid = 0; issueRd = 0;
        aluValid = 0; aluRd = 0; aluData = 0;
        ldValid = 0; ldRd = 0; ldData = 0;
        rst_n = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        check("rst_regWrite", 64'(regWrite), 64'd0);
        check("rst_busy", 64'(busyMask), 64'd0);
        check("rst_ldCount", 64'(ldCount), 64'd0);
        check("rst_ldReady", 64'(ldReady), 64'd1);
        step(); step();
        rst_n = 1'b1;
        step();
        check("idle_regWrite", 64'(regWrite), 64'd0);

        // ALU only, with busy[5] set by a prior issue
        issueValid = 1; issueRd = 5;
        step();
        issueValid = 0;
        check("issue5_busy", 64'(busyMask), 64'h20);
        aluValid = 1; aluRd = 5; aluData = 64'hDEAD_BEEF;
        step();
        aluValid = 0;
        check("alu_regWrite", 64'(regWrite), 64'd1);
        check("alu_wreg", 64'(writeRegister), 64'd5);
        check("alu_wdata", writeData, 64'hDEAD_BEEF);
        check("alu_busy_clr", 64'(busyMask), 64'd0);
        step();
        check("alu_after", 64'(regWrite), 64'd0);

        // Load contention: issue rd1..4, then ALU busy for 6 cycles while loads arrive
        for (int i = 1; i <= 4; i++) begin
            issueValid = 1; issueRd = 5'(i);
            step();
        end
        issueValid = 0;
        check("ld_busy_set", 64'(busyMask), 64'h1E);
        for (int i = 0; i < 6; i++) begin
            aluValid = 1; aluRd = 10; aluData = 64'(i);
            ldValid = 1;
            ldRd = (i < 4) ? 5'(i + 1) : 5'd31;
            ldData = (i < 4) ? 64'(32'h100 + i) : 64'hFF;
            step();
            check("cont_wreg", 64'(writeRegister), 64'd10);
            check("cont_wdata", writeData, 64'(i));
            check("cont_count", 64'(ldCount), (i < 4) ? 64'(i + 1) : 64'd4);
            check("cont_ready", 64'(ldReady), (i < 3) ? 64'd1 : 64'd0);
        end
        aluValid = 0; ldValid = 0;
        check("cont_busy_hold", 64'(busyMask), 64'h1E);
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_regWrite", 64'(regWrite), 64'd1);
            check("drain_wreg", 64'(writeRegister), 64'(i + 1));
            check("drain_wdata", writeData, 64'(32'h100 + i));
            check("drain_count", 64'(ldCount), 64'(3 - i));
            check("drain_ready", 64'(ldReady), 64'd1);
        end
        check("drain_busy", 64'(busyMask), 64'd0);
        step();
        check("drain_idle", 64'(regWrite), 64'd0);

        // x0 handling: ALU to x0, then a load to x0 followed by a load to rd3
        issueValid = 1; issueRd = 3;
        step();
        issueValid = 1; issueRd = 0;
        aluValid = 1; aluRd = 0; aluData = 64'h1234;
        step();
        issueValid = 0; aluValid = 0;
        check("x0_alu_regWrite", 64'(regWrite), 64'd0);
        check("x0_alu_busy", 64'(busyMask), 64'h8);
        ldValid = 1; ldRd = 0; ldData = 64'hAB;
        step();
        check("x0_ld_count1", 64'(ldCount), 64'd1);
        ldRd = 3; ldData = 64'h33;
        step();
        ldValid = 0;
        check("x0_ld_regWrite", 64'(regWrite), 64'd0);
        check("x0_ld_count_pp", 64'(ldCount), 64'd1);
        step();
        check("x0_next_regWrite", 64'(regWrite), 64'd1);
        check("x0_next_wreg", 64'(writeRegister), 64'd3);
        check("x0_next_wdata", writeData, 64'h33);
        check("x0_next_count", 64'(ldCount), 64'd0);
        check("x0_next_busy", 64'(busyMask), 64'd0);

        // Scoreboard race on rd7
        issueValid = 1; issueRd = 7;
        step();
        aluValid = 1; aluRd = 7; aluData = 64'h77;
        step();
        issueValid = 0;
        check("race_regWrite", 64'(regWrite), 64'd1);
        check("race_busy", 64'(busyMask), 64'h80);
        step();
        aluValid = 0;
        check("race_clear", 64'(busyMask), 64'd0);

        // Load latency (and forwarding view when built in)
        step();
        ldValid = 1; ldRd = 9; ldData = 64'h55;
        step();
        ldValid = 0;
        check("lat_not_yet", 64'(regWrite), 64'd0);
`ifdef WB_FWD_EN
        check("fwd_valid", 64'(fwdValid), 64'd1);
        check("fwd_rd", 64'(fwdRd), 64'd9);
        check("fwd_data", fwdData, 64'h55);
`endif
        step();
        check("lat_regWrite", 64'(regWrite), 64'd1);
        check("lat_wreg", 64'(writeRegister), 64'd9);
        check("lat_wdata", writeData, 64'h55);

        // Reset mid-traffic with 3 FIFO entries held back by ALU traffic
        issueValid = 1; issueRd = 12;
        step();
        issueValid = 0;
        for (int i = 0; i < 3; i++) begin
            aluValid = 1; aluRd = 11; aluData = 64'hAA;
            ldValid = 1; ldRd = 5'(i + 1); ldData = 64'(i);
            step();
        end
        check("mid_count3", 64'(ldCount), 64'd3);
        check("mid_regWrite", 64'(regWrite), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_regWrite", 64'(regWrite), 64'd0);
        check("arst_wreg", 64'(writeRegister), 64'd0);
        check("arst_wdata", writeData, 64'd0);
        check("arst_busy", 64'(busyMask), 64'd0);
        check("arst_count", 64'(ldCount), 64'd0);
        check("arst_ready", 64'(ldReady), 64'd1);
        aluValid = 0; ldValid = 0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_regWrite1", 64'(regWrite), 64'd0);
        check("post_rst_count", 64'(ldCount), 64'd0);
        step();
        check("post_rst_regWrite2", 64'(regWrite), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
